// File: rtl/gate_stim_seq.sv
// Stimulus sequencer for a 2-input gate: walks {a,b} = 00..11, holds each vector, samples gate_out.
// Define GATE_SEQ_CHECK_EN to add truth-table comparison and a saturating mismatch counter (err_cnt).
module gate_stim_seq #(
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned LOOPS       = 1,
    parameter logic [3:0]  EXP_TT      = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       gate_out,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic [1:0] vec_idx,
    output logic       sample,
    output logic       sample_vld,
    output logic [3:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] LOOPS_W   = 4'(LOOPS);

    state_t     state_reg, state_next;
    logic [7:0] hold_cnt_reg;
    logic [3:0] loop_cnt_reg;
    logic [1:0] vec_idx_reg;
    logic       sample_reg;
    logic       sample_vld_reg;
    logic       take;
    logic       launch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FIN hands straight back to RUN when start is still high, giving back-to-back runs.
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        done       = 1'b0;
        take       = (state_reg == RUN) && (hold_cnt_reg == HOLD_LAST);
        launch     = start && ((state_reg == IDLE) || (state_reg == FIN));
        case (state_reg)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (take && (vec_idx_reg == 2'd3) && ((loop_cnt_reg + 4'd1) == LOOPS_W))
                    state_next = FIN;
            end
            FIN: begin
                done       = 1'b1;
                state_next = start ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg   <= '0;
            loop_cnt_reg   <= '0;
            vec_idx_reg    <= '0;
            sample_reg     <= 1'b0;
            sample_vld_reg <= 1'b0;
        end else begin
            sample_vld_reg <= take;
            if (take) sample_reg <= gate_out;
            if (launch) begin
                hold_cnt_reg <= '0;
                loop_cnt_reg <= '0;
                vec_idx_reg  <= '0;
            end else if (state_reg == RUN) begin
                if (take) begin
                    hold_cnt_reg <= '0;
                    vec_idx_reg  <= vec_idx_reg + 2'd1;
                    if (vec_idx_reg == 2'd3) loop_cnt_reg <= loop_cnt_reg + 4'd1;
                end else begin
                    hold_cnt_reg <= hold_cnt_reg + 8'd1;
                end
            end
        end
    end

`ifdef GATE_SEQ_CHECK_EN
    logic [3:0] err_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (launch) begin
            err_cnt_reg <= '0;
        end else if (take && (gate_out ^ EXP_TT[vec_idx_reg]) && (err_cnt_reg != 4'd15)) begin
            err_cnt_reg <= err_cnt_reg + 4'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`else
    assign err_cnt = 4'd0;
`endif

    // vec_idx wraps to 0 on the final sample, so a/b read 00 in FIN and IDLE without extra gating.
    assign vec_idx    = vec_idx_reg;
    assign a          = vec_idx_reg[1];
    assign b          = vec_idx_reg[0];
    assign sample     = sample_reg;
    assign sample_vld = sample_vld_reg;

endmodule

// File: tb/tb_gate_stim_seq.sv
// Randomized bench for gate_stim_seq: two instances (long hold / many loops, and HOLD=1) checked
// each cycle against a run-position model; the attached gate is a random truth table.
module tb_gate_stim_seq;

    localparam int H0 = 3;
    localparam int L0 = 6;
    localparam int H1 = 1;
    localparam int L1 = 1;
    localparam logic [3:0] ETT = 4'b1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] tt = 4'b1000;
    logic       start_v [2];
    logic       a_o [2], b_o [2], busy_o [2], done_o [2], smp_o [2], vld_o [2], g_o [2];
    logic [1:0] vec_o [2];
    logic [3:0] err_o [2];

    int checks = 0;
    int errors = 0;
    int pos [2];
    int hold_p [2];
    int loops_p [2];
    logic       exp_smp [2];
    logic       exp_vld [2];
    int         exp_err [2];
    int         runs_done = 0;

    always #5 clk = ~clk;

    assign g_o[0] = tt[{a_o[0], b_o[0]}];
    assign g_o[1] = tt[{a_o[1], b_o[1]}];

    gate_stim_seq #(.HOLD_CYCLES(H0), .LOOPS(L0), .EXP_TT(ETT)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .gate_out(g_o[0]),
        .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]), .done(done_o[0]), .vec_idx(vec_o[0]),
        .sample(smp_o[0]), .sample_vld(vld_o[0]), .err_cnt(err_o[0])
    );

    gate_stim_seq #(.HOLD_CYCLES(H1), .LOOPS(L1), .EXP_TT(ETT)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .gate_out(g_o[1]),
        .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]), .done(done_o[1]), .vec_idx(vec_o[1]),
        .sample(smp_o[1]), .sample_vld(vld_o[1]), .err_cnt(err_o[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            pos[i] = -1; exp_smp[i] = 1'b0; exp_vld[i] = 1'b0; exp_err[i] = 0;
        end
    endtask

    // pos = clocks since the run began (0 .. 4*L*H-1 busy, 4*L*H is the done cycle), -1 when idle.
    task automatic model_step(input int i);
        int p, run_len, v;
        logic g;
        p = pos[i];
        run_len = 4 * loops_p[i] * hold_p[i];
        exp_vld[i] = 1'b0;
        if (p >= 0 && p < run_len && (p % hold_p[i]) == hold_p[i] - 1) begin
            v = (p / hold_p[i]) % 4;
            g = tt[v];
            exp_smp[i] = g;
            exp_vld[i] = 1'b1;
            if (g != ETT[v] && exp_err[i] < 15) exp_err[i]++;
        end
        if (p >= 0 && p < run_len) begin
            pos[i] = p + 1;
        end else if (start_v[i]) begin
            pos[i] = 0;
            exp_err[i] = 0;
        end else begin
            pos[i] = -1;
        end
    endtask

    task automatic check_outputs(input int i);
        int p, run_len, v;
        logic e_busy;
        p = pos[i];
        run_len = 4 * loops_p[i] * hold_p[i];
        e_busy = (p >= 0 && p < run_len);
        v = e_busy ? (p / hold_p[i]) % 4 : 0;
        chk($sformatf("busy%0d", i), busy_o[i], e_busy);
        chk($sformatf("done%0d", i), done_o[i], p == run_len);
        chk($sformatf("vec%0d", i), vec_o[i], v);
        chk($sformatf("a%0d", i), a_o[i], v[1]);
        chk($sformatf("b%0d", i), b_o[i], v[0]);
        chk($sformatf("sample%0d", i), smp_o[i], exp_smp[i]);
        chk($sformatf("vld%0d", i), vld_o[i], exp_vld[i]);
`ifdef GATE_SEQ_CHECK_EN
        chk($sformatf("err%0d", i), err_o[i], exp_err[i]);
`else
        chk($sformatf("err%0d", i), err_o[i], 0);
`endif
        if (done_o[i] === 1'b1 && i == 0) begin
            runs_done++;
            $display("run %0d inst%0d done tt=%b err_cnt=%0d t=%0t", runs_done, i, tt, err_o[i], $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_outputs(0);
        check_outputs(1);
    endtask

    task automatic do_reset_midrun();
        #2;
        rst_n = 1'b0;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        #1;
        model_reset();
        check_outputs(0);
        check_outputs(1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        int mode;
        hold_p[0] = H0; loops_p[0] = L0;
        hold_p[1] = H1; loops_p[1] = L1;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        model_reset();
        #12;
        check_outputs(0);
        check_outputs(1);
        #3 rst_n = 1'b1;

        // Abort a run 17 cycles in, then a fresh full run must be clean.
        cycle();
        start_v[0] = 1'b1;
        start_v[1] = 1'b1;
        cycle();
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        repeat (17) cycle();
        do_reset_midrun();

        // Directed episodes: AND gate pulse, OR gate pulse, stuck-1 held; then random ones.
        for (int ep = 0; ep < 36; ep++) begin
            if (ep == 0)      begin tt = 4'b1000; mode = 0; end
            else if (ep == 1) begin tt = 4'b1110; mode = 0; end
            else if (ep == 2) begin tt = 4'b1111; mode = 1; end
            else begin
                tt = 4'($urandom);
                if ($urandom_range(0, 3) == 0) tt = 4'b1111;
                mode = $urandom_range(0, 2);
            end
            for (int c = 0; c < 160; c++) begin
                case (mode)
                    0: begin start_v[0] = (c == 0); start_v[1] = (c == 0); end
                    1: begin start_v[0] = 1'b1;     start_v[1] = 1'b1;     end
                    default: begin
                        start_v[0] = ($urandom_range(0, 7) == 0);
                        start_v[1] = ($urandom_range(0, 3) == 0);
                    end
                endcase
                cycle();
            end
            start_v[0] = 1'b0;
            start_v[1] = 1'b0;
            if (ep == 20) begin
                start_v[0] = 1'b1;
                cycle();
                start_v[0] = 1'b0;
                repeat (5) cycle();
                do_reset_midrun();
            end
        end

        chk("runs_seen", (runs_done > 3), 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
